l2_port_arbiter: RTL
====================

// Module: l2_port_arbiter
// PURPOSE
// - Shares the single L2 line port between the L1I miss path (read-only) and the L1D miss/writeback path (read/write).
// - Sits below both L1 caches and above L2, so the IF and MEM stages see independent ports while L2 sees one requester.
// - Grants one whole-line transaction at a time and holds the grant until L2 responds.
// - Latches the address and write data at grant, so L2 sees stable command inputs for the whole transaction.
// PARAMETERS
// - ADDR_WIDTH  16   byte address width (lc3b_word)
// - LINE_WIDTH  128  cache line width in bits
// PORTS
// - clk       in   1           system clock; all state updates on its rising edge
// - reset     in   1           synchronous reset, active-high
// - i_addr    in   ADDR_WIDTH  L1I miss line address
// - i_read    in   1           L1I line read request; held high until i_resp
// - i_resp    out  1           L1I transaction-complete strobe
// - i_rdata   out  LINE_WIDTH  line data returned to L1I
// - d_addr    in   ADDR_WIDTH  L1D line address
// - d_read    in   1           L1D line read request; held high until d_resp
// - d_write   in   1           L1D line writeback request; held high until d_resp
// - d_wdata   in   LINE_WIDTH  writeback line data
// - d_resp    out  1           L1D transaction-complete strobe
// - d_rdata   out  LINE_WIDTH  line data returned to L1D
// - l2_addr   out  ADDR_WIDTH  latched address presented to L2
// - l2_read   out  1           L2 read strobe
// - l2_write  out  1           L2 write strobe
// - l2_wdata  out  LINE_WIDTH  latched write data presented to L2
// - l2_resp   in   1           L2 completion strobe
// - l2_rdata  in   LINE_WIDTH  L2 read data; valid when l2_resp is high
// - arb_busy  out  1           high in any state other than IDLE
// BEHAVIOUR
// - FSM states: IDLE, SERVE_I, SERVE_D.
// - Reset values:
//   - state = IDLE, last_grant = I.
//   - l2_read, l2_write, i_resp, d_resp, arb_busy all 0.
//   - Latched addr/wdata registers = 0.
// - IDLE:
//   - Samples the requests each cycle; req_i = i_read, req_d = d_read | d_write.
//   - On a grant, latches the winner's address, plus d_wdata and the op for D.
//   - Moves to SERVE_x on the next edge. No L2 strobe is driven while in IDLE.
// - SERVE_I / SERVE_D:
//   - l2_read or l2_write is held high from the latched op every cycle until l2_resp.
//   - l2_addr and l2_wdata come from the latches, not the live inputs.
// - Completion:
//   - In the cycle l2_resp=1, the granted side's *_resp = 1 (combinational from l2_resp).
//   - i_rdata/d_rdata follow l2_rdata combinationally; the non-granted resp stays 0.
//   - Next state is IDLE and last_grant is updated.
//   - One IDLE bubble always separates transactions, so the requester can drop its request after resp.
// - Latency: request seen in IDLE at cycle N; L2 strobe at N+1; best-case resp at N+1 if L2 answers in one cycle.
// - Simultaneous req_i and req_d in IDLE: D wins (fixed priority), unless ARB_ROUND_ROBIN_EN is defined.
// - d_read and d_write both high: treated as a write (writeback precedes refill in L1D).
// - Requester drops its request mid-transaction: the L2 transaction still completes and the resp pulse is still issued.
// - A new request arriving during SERVE_x waits; it is sampled in the following IDLE cycle.
// - l2_resp while in IDLE: ignored; no resp is forwarded.
// - Reset mid-transaction: state = IDLE and strobes are 0 after that edge; the in-flight L2 op is abandoned.
// - No internal timeout; the arbiter waits on L2 indefinitely.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined:
//   - On a simultaneous request, the side not in last_grant wins.
//   - last_grant updates on every completion, so each side gets at most one back-to-back loss.
// - ARB_ROUND_ROBIN_EN undefined: fixed D-over-I priority; the last_grant register is removed.
// TESTING
// - Only i_read=1 at 0x1230; L2 answers after 3 cycles -> l2_read high 3 cycles; l2_addr=0x1230; i_resp pulses 1 cycle; i_rdata=l2_rdata; d_resp stays 0.
// - d_write=1 at 0x4000, d_wdata=0xDEAD...; d_wdata changed mid-transaction -> l2_write=1, l2_wdata holds the value latched at grant; d_resp on l2_resp.
// - i_read and d_read both high with round-robin off -> D served first, then a 1-cycle IDLE gap, then I served; 2 L2 transactions total.
// - Same stimulus with ARB_ROUND_ROBIN_EN, last_grant=D -> I served first; repeat with both pending -> D then I alternately.
// - reset asserted in cycle 2 of SERVE_D -> next cycle state IDLE; l2_read/l2_write=0; no d_resp; a later l2_resp is ignored.
// - d_read and d_write both high -> l2_write=1, l2_read=0; l2_resp while IDLE -> no resp forwarded.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
// Shares the single L2 line port between the L1I miss path (read-only) and
// the L1D miss/writeback path (read/write). One whole-line transaction is
// granted at a time; the grant is held until L2 responds, then the arbiter
// returns to IDLE for one cycle before the next grant.
//
// Address, write data and operation are latched at grant so L2 sees stable
// command inputs for the whole transaction, regardless of what the
// requesters do with their live inputs afterwards.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate, using
//                                    a last-grant register
//                       undefined -> fixed D-over-I priority, no last-grant
//                                    register
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_addr, i_read      L1I line read request (held until i_resp)
//   i_resp, i_rdata     L1I completion strobe and returned line
//   d_addr, d_read,     L1D line request; d_write is a writeback with
//   d_write, d_wdata    line data d_wdata (held until d_resp)
//   d_resp, d_rdata     L1D completion strobe and returned line
//   l2_addr, l2_read,   latched command presented to L2
//   l2_write, l2_wdata
//   l2_resp, l2_rdata   L2 completion strobe and read data
//   arb_busy            high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module l2_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic                  l2_resp,
    input  logic [LINE_WIDTH-1:0] l2_rdata,

    output logic                  arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_op_write;

    logic                  w_req_i;
    logic                  w_req_d;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_serving;

    // Request qualification
    assign w_req_i = i_read;
    assign w_req_d = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D won the most recently completed transaction
    logic r_last_grant_d;

    // On a tie the side that did not win last time gets the port
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_req_i && w_req_d) begin
            w_grant_d = ~r_last_grant_d;
            w_grant_i = r_last_grant_d;
        end else begin
            w_grant_d = w_req_d;
            w_grant_i = w_req_i;
        end
    end

    // Last-grant history, updated on every completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant_d <= 1'b0;
        end else if (l2_resp && (r_state != ST_IDLE)) begin
            r_last_grant_d <= (r_state == ST_SERVE_D);
        end
    end
`else
    // Fixed priority: D always beats I
    assign w_grant_d = w_req_d;
    assign w_grant_i = w_req_i & ~w_req_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; completion always returns to IDLE for one bubble
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = ST_SERVE_D;
                end else if (w_grant_i) begin
                    w_state_nxt = ST_SERVE_I;
                end
            end
            ST_SERVE_I,
            ST_SERVE_D: begin
                if (l2_resp) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command latch, loaded only on a grant out of IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_op_write <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_d) begin
                r_addr     <= d_addr;
                r_wdata    <= d_wdata;
                // read+write together is a writeback ahead of the refill
                r_op_write <= d_write;
            end else if (w_grant_i) begin
                r_addr     <= i_addr;
                r_op_write <= 1'b0;
            end
        end
    end

    // Output decode from the registered state and latched op
    always_comb begin
        w_serving = 1'b0;
        l2_read   = 1'b0;
        l2_write  = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        arb_busy  = 1'b0;
        case (r_state)
            ST_SERVE_I: begin
                w_serving = 1'b1;
                arb_busy  = 1'b1;
                i_resp    = l2_resp;
            end
            ST_SERVE_D: begin
                w_serving = 1'b1;
                arb_busy  = 1'b1;
                d_resp    = l2_resp;
            end
            default: begin
                w_serving = 1'b0;
            end
        endcase
        l2_read  = w_serving & ~r_op_write;
        l2_write = w_serving &  r_op_write;
    end

    assign l2_addr  = r_addr;
    assign l2_wdata = r_wdata;

    // Read data is only meaningful alongside the matching resp strobe
    assign i_rdata  = l2_rdata;
    assign d_rdata  = l2_rdata;

endmodule
